// File: rtl/pipe_drain_buffer.sv
// Receive-side buffer for a fixed-latency, non-stallable pipe. Credits handed to the
// issuer bound in-flight plus stored results to DEPTH, so the buffer never overflows.
module pipe_drain_buffer #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             issue_ready,
    input  logic             issue_valid,
    input  logic             pipe_valid,
    input  logic [WIDTH-1:0] pipe_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] level,
    output logic [CNT_W-1:0] credits_used,
    output logic             err_sticky
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    generate
        if (LATENCY < 1 || DEPTH < 1) begin : g_bad_params
            $error("pipe_drain_buffer: LATENCY and DEPTH must both be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] level_reg, level_next;
    logic [CNT_W-1:0] credits_reg, credits_next;
    logic             err_reg, err_next;
    logic             inc, dec, full, wr_en;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign issue_ready  = !reset && (credits_reg < DEPTH_C);
    assign out_valid    = (level_reg != '0);
    assign out_data     = mem[rd_ptr_reg];
    assign level        = level_reg;
    assign credits_used = credits_reg;
    assign err_sticky   = err_reg;

    always_comb begin
        inc          = issue_valid && issue_ready;
        dec          = out_valid && out_ready;
        full         = (level_reg == DEPTH_C);
        // A full buffer still accepts a write when the head leaves in the same cycle.
        wr_en        = pipe_valid && (!full || dec);
        credits_next = credits_reg;
        level_next   = level_reg;
        rd_ptr_next  = rd_ptr_reg;
        wr_ptr_next  = wr_ptr_reg;
        err_next     = err_reg | (issue_valid && !issue_ready) | (pipe_valid && !wr_en);

        if (inc && !dec) begin
            credits_next = credits_reg + 1'b1;
        end else if (!inc && dec) begin
            credits_next = credits_reg - 1'b1;
        end

        if (wr_en && !dec) begin
            level_next = level_reg + 1'b1;
        end else if (!wr_en && dec) begin
            level_next = level_reg - 1'b1;
        end

        if (wr_en) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (dec) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credits_reg <= '0;
            level_reg   <= '0;
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            err_reg     <= 1'b0;
        end else begin
            credits_reg <= credits_next;
            level_reg   <= level_next;
            rd_ptr_reg  <= rd_ptr_next;
            wr_ptr_reg  <= wr_ptr_next;
            err_reg     <= err_next;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_ptr_reg] <= pipe_data;
        end
    end

endmodule
